// File: rtl/systolic_result_collector_if.sv
// Row stream from the result collector to the output writer.
// Master drives row_data/row_valid, slave drives row_ready.
interface systolic_result_collector_if #(
  parameter int COLS  = 4,
  parameter int SUM_W = 16
);
  logic [COLS*SUM_W-1:0] row_data;
  logic                  row_valid;
  logic                  row_ready;

  modport master (
    output row_data,
    output row_valid,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_valid,
    output row_ready
  );
endinterface

// File: rtl/systolic_result_collector.sv
// De-skews the bottom-row partial sums of the PE array into whole rows
// and queues them in a first-word-fall-through FIFO for the output writer.
module systolic_result_collector #(
  parameter int COLS  = 4,
  parameter int SUM_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [COLS*SUM_W-1:0]     mac_in,
  input  logic [COLS-1:0]           active_in,
  systolic_result_collector_if.master rows,
  output logic [15:0]               row_count,
  output logic                      overflow,
  output logic                      skew_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = COLS * SUM_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef logic [RW-1:0] row_t;

  // Column c enters at stage c and leaves at stage COLS-1.
  logic [SUM_W-1:0] dat_q [COLS][COLS];
  logic [SUM_W-1:0] dat_d [COLS][COLS];
  logic [COLS-1:0]  vld_q [COLS];
  logic [COLS-1:0]  vld_d [COLS];

  row_t            mem_q [DEPTH];
  row_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [15:0]     row_count_q, row_count_d;
  logic            ovf_q, ovf_d;
  logic            skew_q, skew_d;

  row_t            al_row;
  logic [COLS-1:0] al_vld;
  logic            all_v;
  logic            any_v;
  logic            not_empty;
  logic            pop;
  logic            push_req;
  logic            push_ok;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      for (int s = 0; s < COLS; s++) begin
        dat_d[c][s] = '0;
        vld_d[c][s] = 1'b0;
        if (s == c) begin
          dat_d[c][s] = mac_in[c*SUM_W +: SUM_W];
          vld_d[c][s] = active_in[c] & ~clear;
        end else if (s > c) begin
          dat_d[c][s] = dat_q[c][s-1];
          vld_d[c][s] = vld_q[c][s-1] & ~clear;
        end
      end
    end
  end

  always_comb begin
    al_row = '0;
    al_vld = '0;
    for (int c = 0; c < COLS; c++) begin
      al_row[c*SUM_W +: SUM_W] = dat_q[c][COLS-1];
      al_vld[c]                = vld_q[c][COLS-1];
    end
  end

  assign all_v     = &al_vld;
  assign any_v     = |al_vld;
  assign not_empty = (cnt_q != '0);
  assign pop       = not_empty & rows.row_ready & ~clear;
  assign push_req  = all_v & ~clear;
  // A full FIFO still takes a row when the head leaves on the same edge.
  assign push_ok   = push_req & ((cnt_q < DEPTH_C) | pop);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    row_count_d = row_count_q;
    ovf_d       = ovf_q;
    skew_d      = skew_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      row_count_d = '0;
      ovf_d       = 1'b0;
      skew_d      = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = al_row;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        row_count_d = row_count_q + 16'd1;
      end
      unique case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      ovf_d  = ovf_q | (push_req & ~push_ok);
      skew_d = skew_q | (any_v & ~all_v);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q       <= '{default: '0};
      vld_q       <= '{default: '0};
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      row_count_q <= '0;
      ovf_q       <= 1'b0;
      skew_q      <= 1'b0;
    end else begin
      dat_q       <= dat_d;
      vld_q       <= vld_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      row_count_q <= row_count_d;
      ovf_q       <= ovf_d;
      skew_q      <= skew_d;
    end
  end

  assign rows.row_valid = not_empty;
  assign rows.row_data  = not_empty ? mem_q[rd_ptr_q] : '0;
  assign row_count      = row_count_q;
  assign overflow       = ovf_q;
  assign skew_err       = skew_q;

endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Sits at the bottom edge of the PE systolic array and consumes the skewed partial-sum stream that leaves the last PE row (mac_out plus active_out per column).
- Realigns the column skew and packs one result row per matrix row.
- Buffers rows in a small FIFO and hands them to the output writer over a valid/ready handshake.
- Opposite end of the interface the feeder and PEs drive.

Parameters:
COLS, 4, number of array columns (>=2)
SUM_W, 16, width of one column partial sum (matches PE mac_out)
DEPTH, 8, FIFO depth in rows (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush of delay lines and FIFO; clears sticky flags
mac_in  input  COLS*SUM_W  bottom-row mac_out; column c at [c*SUM_W +: SUM_W]
active_in  input  COLS  bottom-row active_out; bit c qualifies column c
row_data  output  COLS*SUM_W  head-of-FIFO row, same packing as mac_in
row_valid  output  1  FIFO non-empty
row_ready  input  1  consumer accepts row_data when row_valid&&row_ready
row_count  output  16  rows popped since reset/clear, wraps at 0xFFFF->0
overflow  output  1  sticky: aligned row dropped because FIFO full
skew_err  output  1  sticky: aligned slot had some but not all columns valid

Behaviour:
- Reset (async, any time, including mid-transfer) immediately drives:
  - row_data=0, row_valid=0, row_count=0, overflow=0, skew_err=0.
  - All delay-line and FIFO state empty.
  - First capture occurs on the first rising edge after reset deasserts.
- Capture: every edge, column c registers {active_in[c], mac_in[c]} into its input stage.
- De-skew: column c then passes through COLS-1-c further register stages. Column COLS-1 has none.
  - Data presented on column 0 in cycle n and on column c in cycle n+c arrive aligned after edge n+COLS-1.
- Aligned slot rules:
  - All COLS valid bits =1: row push attempted at edge n+COLS.
  - All valid bits =0: nothing happens.
  - Mixed: no push; skew_err set.
- Push acceptance:
  - Accepted if FIFO count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the row is dropped and overflow is set. Stored rows are never overwritten.
- Latency: with an empty FIFO, row_valid=1 and row_data valid in cycle n+COLS+1.
- FIFO behaviour:
  - First-word-fall-through: row_data always shows the oldest row and is held stable while row_valid&&!row_ready.
  - row_data=0 when empty.
- Pop: occurs on edge when row_valid&&row_ready; row_count increments by 1 on each pop.
- Simultaneous push and pop:
  - Count unchanged; both succeed, including at full.
  - At count==1, the new row becomes head after the edge.
- Empty with push: row_valid rises the cycle after the push edge. There is no bypass in the same cycle.
- clear=1 at an edge:
  - FIFO emptied, delay lines invalidated, row_count=0, overflow=0, skew_err=0.
  - Any concurrent push or pop is ignored.
  - Data captured in the same cycle as clear is discarded.
- Arithmetic: none on data. Values pass bit-exact with no sign extension or saturation.
- Pointers: log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits.

Test Plan:
- Single row, COLS=4, row_ready=1: drive col0=0x0011 (cycle 0), col1=0x0022 (1), col2=0x0033 (2), col3=0x0044 (3), each with its active bit for one cycle -> row_valid=1 in cycle 5 with row_data=0x0044_0033_0022_0011, one-cycle pulse, row_count=1.
- Backpressure/overflow: row_ready=0, 10 back-to-back skewed rows with col values k, k+0x100, k+0x200, k+0x300 for k=1..10 -> 8 rows stored, overflow=1. Raising row_ready drains rows k=1..8 in order; row_count=8.
- Full with simultaneous push/pop: fill 8 rows, then hold row_ready=1 while streaming 4 more rows -> no overflow, all 12 rows popped in order, row_count=12.
- Skew error: row where column 2 active bit is 0 -> no row_valid, skew_err=1 sticky. The next complete row is collected normally.
- Reset mid-operation: 3 rows buffered, row_valid=1; assert reset between edges -> row_valid, row_data, row_count and flags read 0 before the next edge. After release, a fresh row appears with latency 5.
- Clear: 2 rows buffered, overflow=1, row_count=5; pulse clear -> next cycle row_valid=0, row_count=0, overflow=0. A row in flight in the delay line is not emitted.
